// File: rtl/irda_crc_pkg.sv
// ----------------------------------------------------------------------------
// irda_crc_pkg
// Shared definitions for the FIR-path CRC engine:
//   - standard polynomial / init / residue constants
//   - engine state type
//   - crc_step: MSB-first multi-bit CRC update for any width 8..32 and any
//     step size 1..8. Operands are carried right-aligned in 32/8-bit
//     containers; the function left-aligns them internally so the feedback
//     bit is always bit 31 regardless of crc_w.
// ----------------------------------------------------------------------------
package irda_crc_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
   localparam logic [31:0] CRC16_CCITT   = 32'h0000_1021;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_APPEND = 2'd2,
      ST_CHECK  = 2'd3
   } state_e;

   // crc and poly are right-aligned in the low crc_w bits; word is
   // right-aligned in the low din_w bits, word[din_w-1] processed first.
   function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                            input logic [7:0]  word,
                                            input logic [31:0] poly,
                                            input int          crc_w,
                                            input int          din_w);
      logic [31:0] c;
      logic [31:0] p;
      logic [7:0]  w;
      logic        fb;
      c = crc  << (32 - crc_w);
      p = poly << (32 - crc_w);
      w = word << (8 - din_w);
      for (int i = 0; i < 8; i++) begin
         if (i < din_w) begin
            fb = c[31] ^ w[7];
            c  = {c[30:0], 1'b0} ^ (fb ? p : 32'd0);
            w  = {w[6:0], 1'b0};
         end
      end
      return c >> (32 - crc_w);
   endfunction

endpackage

// File: rtl/irda_crc_engine_if.sv
// ----------------------------------------------------------------------------
// irda_crc_engine_if
// Bus between the FIR serialiser/deserialiser side and the CRC engine.
//   master : drives en, mode, sof, din, din_last, bdcrc;
//            observes dout, crc_busy, done, crc_ok, crc_err, crc_par_o
//   slave  : the CRC engine (opposite directions)
// ----------------------------------------------------------------------------
interface irda_crc_engine_if #(
   parameter int CRC_W = 32,
   parameter int DIN_W = 1
);
   logic             en;
   logic             mode;
   logic             sof;
   logic [DIN_W-1:0] din;
   logic             din_last;
   logic             bdcrc;
   logic [DIN_W-1:0] dout;
   logic             crc_busy;
   logic             done;
   logic             crc_ok;
   logic             crc_err;
   logic [CRC_W-1:0] crc_par_o;

   modport master (
      output en, mode, sof, din, din_last, bdcrc,
      input  dout, crc_busy, done, crc_ok, crc_err, crc_par_o
   );

   modport slave (
      input  en, mode, sof, din, din_last, bdcrc,
      output dout, crc_busy, done, crc_ok, crc_err, crc_par_o
   );
endinterface

// File: rtl/irda_crc_step.sv
// ----------------------------------------------------------------------------
// irda_crc_step
// Combinational DIN_W-bit CRC update (MSB-first), wrapping crc_step.
//   crc_i : current CRC register
//   din_i : data word, din_i[DIN_W-1] processed first
//   crc_o : CRC after DIN_W serial updates
// ----------------------------------------------------------------------------
module irda_crc_step
   import irda_crc_pkg::*;
#(
   parameter int          CRC_W = 32,
   parameter int          DIN_W = 1,
   parameter logic [31:0] POLY  = CRC32_POLY
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic [DIN_W-1:0] din_i,
   output logic [CRC_W-1:0] crc_o
);

   logic [31:0] res;

   assign res   = crc_step(32'(crc_i), 8'(din_i), POLY, CRC_W, DIN_W);
   assign crc_o = res[CRC_W-1:0];

   // Upper bits of the 32-bit container are always zero for narrow CRCs.
   generate
      if (CRC_W < 32) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^res[31:CRC_W];
      end
   endgenerate

endmodule

// File: rtl/irda_crc_engine.sv
// ----------------------------------------------------------------------------
// irda_crc_engine
// CRC generator/checker for the FIR path. TX mode passes data through and
// then appends the complemented FCS; RX mode checks the residue after the
// received FCS and reports a good/bad verdict. Advances only on en.
//   clk      : system clock
//   wb_rst_i : synchronous active-high reset
//   bus      : slave side of irda_crc_engine_if (en, mode, sof, din,
//              din_last, bdcrc in; dout, crc_busy, done, crc_ok, crc_err,
//              crc_par_o out)
// ----------------------------------------------------------------------------
module irda_crc_engine
   import irda_crc_pkg::*;
#(
   parameter int          CRC_W   = 32,
   parameter logic [31:0] POLY    = CRC32_POLY,
   parameter logic [31:0] INIT    = CRC32_INIT,
   parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
   parameter int          DIN_W   = 1
) (
   input  logic              clk,
   input  logic              wb_rst_i,
   irda_crc_engine_if.slave  bus
);

   localparam int               NW       = CRC_W / DIN_W;
   localparam int               CNT_W    = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);
   localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] RES_C    = RESIDUE[CRC_W-1:0];

   generate
      if (!(DIN_W == 1 || DIN_W == 2 || DIN_W == 4 || DIN_W == 8)) begin : g_bad_din
         $error("irda_crc_engine: DIN_W must be 1, 2, 4 or 8");
      end
      if (CRC_W < 8 || CRC_W > 32) begin : g_bad_crc
         $error("irda_crc_engine: CRC_W must be within 8..32");
      end
      if ((CRC_W % DIN_W) != 0) begin : g_bad_ratio
         $error("irda_crc_engine: CRC_W must be a multiple of DIN_W");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CRC_W-1:0] crc_q,   crc_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             mode_q,  mode_d;
   logic             done_q,  done_d;
   logic             ok_q,    ok_d;
   logic             err_q,   err_d;

   logic [CRC_W-1:0] step_in;
   logic [CRC_W-1:0] step_out;
   logic             data_word;
   logic             mode_eff;

   // A word arriving together with sof is folded into INIT, not the old CRC.
   assign step_in = bus.sof ? INIT_C : crc_q;

   irda_crc_step #(
      .CRC_W (CRC_W),
      .DIN_W (DIN_W),
      .POLY  (POLY)
   ) u_step (
      .crc_i (step_in),
      .din_i (bus.din),
      .crc_o (step_out)
   );

   // sof opens a data phase in the same cycle, so its word counts as data.
   assign data_word = bus.en && (bus.sof || (state_q == ST_DATA));
   assign mode_eff  = bus.sof ? bus.mode : mode_q;

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         crc_q   <= INIT_C;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      ok_d    = ok_q;
      err_d   = err_q;
      done_d  = 1'b0;

      // sof from any state restarts the frame; an aborted frame gets no done.
      if (bus.sof) begin
         state_d = ST_DATA;
         mode_d  = bus.mode;
         crc_d   = INIT_C;
         cnt_d   = '0;
         ok_d    = 1'b0;
         err_d   = 1'b0;
      end

      if (data_word) begin
         crc_d = step_out;
         if (bus.din_last) begin
            if (mode_eff) begin
               state_d = ST_APPEND;
               cnt_d   = CNT_LAST;
            end else begin
               state_d = ST_CHECK;
            end
         end
      end else if (!bus.sof) begin
         case (state_q)
            ST_APPEND: begin
               // Plain shift-out: the FCS leaves MSB-first, no feedback.
               if (bus.en) begin
                  crc_d = crc_q << DIN_W;
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_CHECK: begin
               ok_d    = (crc_q == RES_C);
               err_d   = (crc_q != RES_C);
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   assign bus.dout      = (state_q == ST_APPEND)
                        ? (~crc_q[CRC_W-1 -: DIN_W] ^ {DIN_W{bus.bdcrc}})
                        : bus.din;
   assign bus.crc_busy  = (state_q == ST_APPEND);
   assign bus.done      = done_q;
   assign bus.crc_ok    = ok_q;
   assign bus.crc_err   = err_q;
   assign bus.crc_par_o = crc_q;

endmodule
